vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Frame-buffer access scheduler for the VGA display path. It shares one single-port frame-buffer SRAM between CPU pixel writes and display scanline prefetch. It fills a ping-pong line buffer one line ahead of the scan-out, using rows requested by the VGA timing generator. It sits between the CPU bus, the frame-buffer SRAM and the line buffer that feeds the VGA timing/colour output stage.

## Interface
Parameters:
- H_ACTIVE, 640: pixels per displayed line
- V_ACTIVE, 480: displayed lines
- ADDR_W, 19: SRAM word address width; one 24-bit pixel per word
- DATA_W, 24: pixel width, RGB888

Ports:
- Clock and reset: one clock, `pclk`; reset is `reset`, asynchronous and active-high.
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse that requests a prefetch of row `next_v`
- next_v  in  10  row to prefetch; sampled only on `line_start`
- cpu_req  in  1  CPU write request
- cpu_addr  in  ADDR_W  CPU pixel address
- cpu_wdata  in  DATA_W  CPU pixel data
- cpu_ready  out  1  grant; a write transfers when `cpu_req & cpu_ready`
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data; valid 1 cycle after a read
- lb_we  out  1  line-buffer write enable
- lb_waddr  out  10  line-buffer pixel index
- lb_wdata  out  DATA_W  equals `mem_rdata`
- lb_bank  out  1  bank being filled; display reads `~lb_bank`
- line_done  out  1  one-cycle pulse when the last pixel is written to the line buffer
- err_underrun  out  1  sticky; set when a new request arrives before the previous fetch completes

## Operation
- States:
  - IDLE: no fetch in progress; CPU has the SRAM every cycle.
  - FETCH: issuing reads.
  - DRAIN: one cycle to capture the final read.
- IDLE behaviour: `cpu_ready` = 1. A CPU transfer drives `mem_en=1`, `mem_we=1`, `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata` in the same cycle.
- Starting a fetch (`line_start` with `next_v < V_ACTIVE`):
  - latch `base = next_v*640`, computed as `(v<<9)+(v<<7)` and zero-extended to ADDR_W;
  - clear `x` to 0 and `slot` to 0;
  - toggle `lb_bank`;
  - go to FETCH.
- `line_start` with `next_v >= V_ACTIVE` is ignored: no fetch, no bank toggle.
- FETCH arbitration:
  - 3-bit `slot` counter increments every FETCH cycle.
  - At `slot==7` with `cpu_req` high: CPU wins, `cpu_ready=1`.
  - In every other cycle, fetch wins: `cpu_ready=0`, read at `base+x`, then `x++`. This includes `slot==7` when `cpu_req` is low (work-conserving).
- Fetch write-back: a read issued in cycle n gives `lb_we=1` in cycle n+1, with `lb_waddr` equal to the `x` of that read.
- End of fetch: after the read of `x=H_ACTIVE-1`, go to DRAIN. DRAIN writes the last pixel, pulses `line_done`, and returns to IDLE. CPU may win in DRAIN (`cpu_ready=1`).
- CPU writes with `cpu_addr >= H_ACTIVE*V_ACTIVE`: accepted (`cpu_ready` unchanged), SRAM write suppressed (`mem_en=0`).
- Underrun (`line_start` in FETCH or DRAIN):
  - set `err_underrun`;
  - abort the current fetch; its pending read-back is dropped (`lb_we=0`);
  - restart FETCH with the new row and toggle the bank.
- `err_underrun` clears only on reset.

## Timing
- Reset values: state IDLE, `lb_bank=0`, `err_underrun=0`, `x=0`, `slot=0`.
  - While `reset` is high: `cpu_ready=0`, `mem_en=0`, `lb_we=0`, `line_done=0`.
- Uncontended fetch: the first read is in the cycle after `line_start`. 640 read cycles, then `line_done` at cycle 641 after `line_start`.
- Worst case with `cpu_req` held high: 731 issue cycles plus drain. This fits within the 800-cycle line.
- Memory outputs are combinational from state and registers. `cpu_ready` is combinational from state, `slot`, `cpu_req` and `reset`.
- A reset during FETCH returns to IDLE immediately. No `lb_we` or `line_done` is produced after reset deasserts.

## Structure
- Package `vga_pkg`: H_ACTIVE, V_ACTIVE, FB_WORDS (307200), and the state enum (IDLE/FETCH/DRAIN).
- No sub-module. Arbiter FSM, address generator and read-back pipeline register go in one module. `vga_ctrl` remains the timing source that generates `line_start`/`next_v`.

## Test plan
- Idle fetch: `line_start`, `next_v=0`, `cpu_req=0` -> reads of addresses 0..639 on consecutive cycles; `lb_we` with `lb_waddr` 0..639 one cycle later; `line_done` at cycle 641; `lb_bank` 0→1.
- Last row: `next_v=479` -> first `mem_addr=306560`, last `mem_addr=307199`. `next_v=500` -> no `mem_en`, `lb_bank` unchanged.
- Contention: `cpu_req` held high through a fetch -> `cpu_ready` only at `slot==7`; 91 CPU writes; `line_done` at cycle 732; `lb_waddr` monotonic and gap-free.
- Underrun: second `line_start` (`next_v=5`) 100 cycles into a fetch -> `err_underrun=1` and stays set; next read at address 3200 with `x=0`; no `lb_we` for the aborted pending read.
- CPU range: in IDLE, a write with `cpu_addr=307200` -> `cpu_ready=1`, `mem_en=0`. A write with `cpu_addr=42` -> `mem_we=1`, `mem_addr=42` in the same cycle.
- Reset mid-fetch: assert `reset` at x=300 -> outputs go to reset values immediately; after release, state is IDLE and `cpu_ready=1`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA frame-buffer path.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;

   // The arbiter is idle, issuing scanline reads, or capturing the final read.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer access scheduler: shares the single-port frame-buffer SRAM
// between CPU pixel writes and scanline prefetch into a ping-pong line buffer.
// The display always reads the bank opposite to the one being filled.
module vga_fb_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 24
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              line_start,
   input  logic [9:0]        next_v,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [9:0]        lb_waddr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              lb_bank,
   output logic              line_done,
   output logic              err_underrun
);

   import vga_pkg::*;

   // Addresses at or above this limit lie outside the visible frame buffer.
   localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
   localparam logic [9:0]      X_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [9:0]      V_LIMIT  = 10'(V_ACTIVE);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] base_calc;
   logic [9:0]        x;
   logic [2:0]        slot;
   logic              rd_pending;
   logic [9:0]        rd_x;
   logic              start_ok;
   logic              fetch_rd;
   logic              cpu_wr;

   // Row base address is next_v*640, built from two shifts instead of a multiplier.
   always_comb begin
      base_calc = ADDR_W'({next_v, 9'd0}) + ADDR_W'({next_v, 7'd0});
      start_ok  = line_start && (next_v < V_LIMIT);
   end

   // Arbitration and next state: the CPU owns the SRAM outside FETCH, and
   // inside FETCH only on slot 7 when it is actually asking; a valid
   // line_start always (re)starts a fetch, even on top of a running one.
   always_comb begin
      cpu_ready  = 1'b0;
      fetch_rd   = 1'b0;
      state_next = state;
      if (!reset) begin
         case (state)
            IDLE:  cpu_ready = 1'b1;
            FETCH: begin
               if (slot == 3'd7 && cpu_req) begin
                  cpu_ready = 1'b1;
               end else begin
                  fetch_rd = 1'b1;
               end
            end
            DRAIN: cpu_ready = 1'b1;
            default: cpu_ready = 1'b0;
         endcase
      end
      case (state)
         IDLE:    state_next = IDLE;
         FETCH:   state_next = (fetch_rd && x == X_LAST) ? DRAIN : FETCH;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (start_ok) begin
         state_next = FETCH;
      end
   end

   // SRAM and line-buffer outputs; out-of-range CPU writes are acknowledged
   // but never reach the SRAM.
   always_comb begin
      cpu_wr    = cpu_req && cpu_ready && ({1'b0, cpu_addr} < FB_LIMIT);
      mem_en    = fetch_rd || cpu_wr;
      mem_we    = cpu_wr;
      mem_addr  = fetch_rd ? (base + ADDR_W'(x)) : cpu_addr;
      mem_wdata = cpu_wdata;
      lb_we     = rd_pending && !reset;
      lb_waddr  = rd_x;
      lb_wdata  = mem_rdata;
      line_done = (state == DRAIN) && !reset;
   end

   // State register.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Address generator, slot counter, bank/error flags and the read-back
   // register that delays each read's pixel index by the SRAM latency.
   // A restart drops whatever read was issued in the restart cycle.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         base         <= '0;
         x            <= '0;
         slot         <= '0;
         rd_pending   <= 1'b0;
         rd_x         <= '0;
         lb_bank      <= 1'b0;
         err_underrun <= 1'b0;
      end else if (start_ok) begin
         base       <= base_calc;
         x          <= '0;
         slot       <= '0;
         rd_pending <= 1'b0;
         lb_bank    <= ~lb_bank;
         if (state != IDLE) begin
            err_underrun <= 1'b1;
         end
      end else begin
         rd_pending <= fetch_rd;
         if (fetch_rd) begin
            rd_x <= x;
            if (x != X_LAST) begin
               x <= x + 10'd1;
            end
         end
         if (state == FETCH) begin
            slot <= slot + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter against a line-level model.
module tb_vga_fb_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 24;
   localparam int HA     = 640;
   localparam int VA     = 480;

   logic              pclk;
   logic              reset;
   logic              line_start;
   logic [9:0]        next_v;
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              lb_we;
   logic [9:0]        lb_waddr;
   logic [DATA_W-1:0] lb_wdata;
   logic              lb_bank;
   logic              line_done;
   logic              err_underrun;

   int checks = 0;
   int errors = 0;

   // Model of the line fetch in terms of rows, pixels read and elapsed cycles.
   bit m_fetch, m_drain, m_pv, m_bank, m_err;
   int m_row, m_reads, m_age, m_px;

   // Values seen in the most recent cycle, for scenario-level checks.
   bit obs_line_done, obs_cpu_xfer, obs_mem_en, obs_mem_we, obs_lb_we;
   int obs_mem_addr;

   vga_fb_arbiter dut (
      .pclk(pclk), .reset(reset), .line_start(line_start), .next_v(next_v),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
      .lb_bank(lb_bank), .line_done(line_done), .err_underrun(err_underrun)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // One pixel-clock cycle: drive inputs, compare every output with the
   // model mid-cycle, then advance the model across the next rising edge.
   task automatic applyStimulus(input bit rst, input bit ls, input int v, input bit req, input int addr);
      bit e_ready, e_read, e_wr;
      reset      = rst;
      line_start = ls;
      next_v     = 10'(v);
      cpu_req    = req;
      cpu_addr   = ADDR_W'(addr);
      cpu_wdata  = DATA_W'($urandom);
      mem_rdata  = DATA_W'($urandom);
      #4;
      if (rst) begin
         e_ready = 1'b0;
         e_read  = 1'b0;
      end else if (m_fetch) begin
         e_ready = (m_age % 8 == 0) && req;
         e_read  = !e_ready;
      end else begin
         e_ready = 1'b1;
         e_read  = 1'b0;
      end
      e_wr = req && e_ready && (addr < HA * VA);
      checkOutput("cpu_ready", 32'(cpu_ready), 32'(e_ready));
      checkOutput("mem_en", 32'(mem_en), 32'(e_read || e_wr));
      checkOutput("lb_we", 32'(lb_we), 32'(!rst && m_pv));
      checkOutput("line_done", 32'(line_done), 32'(!rst && m_drain));
      checkOutput("lb_bank", 32'(lb_bank), 32'(!rst && m_bank));
      checkOutput("err_underrun", 32'(err_underrun), 32'(!rst && m_err));
      if (e_read || e_wr) begin
         checkOutput("mem_we", 32'(mem_we), 32'(e_wr));
         checkOutput("mem_addr", 32'(mem_addr), e_read ? 32'(m_row * HA + m_reads) : 32'(addr));
      end
      if (e_wr) checkOutput("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      if (!rst && m_pv) begin
         checkOutput("lb_waddr", 32'(lb_waddr), 32'(m_px));
         checkOutput("lb_wdata", 32'(lb_wdata), 32'(mem_rdata));
      end
      obs_line_done = line_done;
      obs_cpu_xfer  = cpu_req && cpu_ready;
      obs_mem_en    = mem_en;
      obs_mem_we    = mem_we;
      obs_lb_we     = lb_we;
      obs_mem_addr  = int'(mem_addr);
      if (rst) begin
         m_fetch = 0; m_drain = 0; m_pv = 0; m_bank = 0; m_err = 0;
         m_row = 0; m_reads = 0; m_age = 0; m_px = 0;
      end else if (ls && v < VA) begin
         if (m_fetch || m_drain) m_err = 1;
         m_bank  = !m_bank;
         m_row   = v;
         m_reads = 0;
         m_age   = 1;
         m_fetch = 1;
         m_drain = 0;
         m_pv    = 0;
      end else begin
         m_pv    = e_read;
         m_px    = m_reads;
         m_drain = 0;
         if (e_read) begin
            m_reads++;
            if (m_reads == HA) begin
               m_fetch = 0;
               m_drain = 1;
            end
         end
         if (m_fetch) m_age++;
      end
      @(posedge pclk);
      #1;
   endtask

   function automatic int randAddr();
      if ($urandom_range(0, 9) == 0) return HA * VA + int'($urandom_range(0, 1000));
      return int'($urandom_range(0, HA * VA - 1));
   endfunction

   // Start a line and run until line_done (bounded); mode 0 no CPU, 1 CPU always, 2 random.
   task automatic runFetch(input int v, input int mode, output int done_cyc, output int nwr,
                           output int first_a, output int last_a);
      bit req;
      applyStimulus(0, 1, v, 0, 0);
      done_cyc = -1; nwr = 0; first_a = -1; last_a = -1;
      for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
         req = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(0, 0, 0, req, randAddr());
         if (obs_line_done) done_cyc = c;
         else if (obs_cpu_xfer) nwr++;
         if (obs_mem_en && !obs_mem_we) begin
            if (first_a < 0) first_a = obs_mem_addr;
            last_a = obs_mem_addr;
         end
      end
   endtask

   initial begin
      int done_cyc, nwr, first_a, last_a, len;
      reset = 1; line_start = 0; next_v = '0; cpu_req = 0;
      cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
      @(posedge pclk);
      #1;
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 42);

      // CPU writes in idle, inside and outside the frame buffer
      applyStimulus(0, 0, 0, 1, 42);
      checkOutput("cpu42_we", 32'(obs_mem_we), 32'd1);
      checkOutput("cpu42_addr", 32'(obs_mem_addr), 32'd42);
      applyStimulus(0, 0, 0, 1, 307200);
      checkOutput("cpu_oor_ready", 32'(obs_cpu_xfer), 32'd1);
      checkOutput("cpu_oor_en", 32'(obs_mem_en), 32'd0);

      // Uncontended fetch of row 0
      runFetch(0, 0, done_cyc, nwr, first_a, last_a);
      checkOutput("idle_done_cycle", 32'(done_cyc), 32'd641);
      checkOutput("idle_first_addr", 32'(first_a), 32'd0);
      checkOutput("idle_last_addr", 32'(last_a), 32'd639);
      checkOutput("idle_bank", 32'(lb_bank), 32'd1);

      // Last row with random CPU traffic
      runFetch(479, 2, done_cyc, nwr, first_a, last_a);
      checkOutput("row479_first", 32'(first_a), 32'd306560);
      checkOutput("row479_last", 32'(last_a), 32'd307199);

      // Out-of-range row is ignored
      applyStimulus(0, 1, 500, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("row500_no_en", 32'(obs_mem_en), 32'd0);
      end
      checkOutput("row500_bank", 32'(lb_bank), 32'd0);

      // Contention: CPU requesting every cycle
      runFetch(int'($urandom_range(0, VA - 1)), 1, done_cyc, nwr, first_a, last_a);
      checkOutput("contend_done_cycle", 32'(done_cyc), 32'd732);
      checkOutput("contend_cpu_writes", 32'(nwr), 32'd91);

      // Underrun: new request 100 cycles into a fetch
      applyStimulus(0, 1, 10, 0, 0);
      for (int i = 1; i < 100; i++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 5, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("underrun_flag", 32'(err_underrun), 32'd1);
      checkOutput("underrun_addr", 32'(obs_mem_addr), 32'd3200);
      checkOutput("underrun_drop", 32'(obs_lb_we), 32'd0);
      done_cyc = -1;
      for (int c = 0; c < 1000 && done_cyc < 0; c++) begin
         applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), randAddr());
         if (obs_line_done) done_cyc = c;
      end
      checkOutput("underrun_completes", 32'(done_cyc >= 0), 32'd1);
      checkOutput("underrun_sticky", 32'(err_underrun), 32'd1);

      // Random rows, random line lengths (some overlap and underrun)
      for (int n = 0; n < 6; n++) begin
         applyStimulus(0, 1, int'($urandom_range(0, 520)), 0, 0);
         len = int'($urandom_range(400, 850));
         for (int c = 0; c < len; c++) applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), randAddr());
      end

      // Reset in the middle of a fetch
      applyStimulus(0, 1, 3, 0, 0);
      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 100);
      checkOutput("rst_mid_ready", 32'(obs_cpu_xfer), 32'd0);
      checkOutput("rst_mid_en", 32'(obs_mem_en), 32'd0);
      applyStimulus(0, 0, 0, 1, 100);
      checkOutput("rst_after_ready", 32'(obs_cpu_xfer), 32'd1);
      checkOutput("rst_after_lb_we", 32'(obs_lb_we), 32'd0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), randAddr());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
